key_encoder_nbit: RTL and testbench

Parametrised binary keypad encoder. It synchronises a small keypad, detects key presses, and shifts '0'/'1' digits into a CODE_W-bit code register. It also supports backspace, clear, an optional idle timeout, a full/done indication and error reporting. It sits between the keypad pins and the code-compare/game logic. A one-cycle done pulse indicates that a complete code is ready.

---
 rtl/key_encoder_nbit.sv | 166 ++++++++++++++++
 tb/tb_key_encoder_nbit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_encoder_nbit.sv
// key_encoder_nbit: keypad front end that synchronises four raw keys, turns
// presses from an all-released keypad into '0'/'1' digits, backspace and
// clear, and builds a CODE_W-digit code with the newest digit in the LSB.
// Optional idle timeout wipes a partially entered code.
module key_encoder_nbit #(
   parameter int CODE_W      = 9,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    keypad,
   output logic [CODE_W-1:0]             keycode,
   output logic [$clog2(CODE_W+1)-1:0]   count,
   output logic                          code_full,
   output logic                          code_done,
   output logic                          key_err,
   output logic                          timeout
);
   localparam int CNT_W = $clog2(CODE_W+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0]                  ksync;
   logic [3:0]                  kprev_q;
   logic                        strobe;
   logic                        onehot;

   state_t                      state_q, state_d;
   logic [CODE_W-1:0]           keycode_q, keycode_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        full_q;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic                        tout_q, tout_d;
   logic                        accept;
   logic                        tmo_hit;
   logic                        tmo_fire;

   assign ksync  = sync_q[SYNC_STAGES-1];
   // A press only counts when it appears on a fully released keypad.
   assign strobe = (|ksync) & ~(|kprev_q);
   assign onehot = $onehot(ksync);
   // Any strobe, even a rejected one, takes priority over the timeout.
   assign tmo_fire = tmo_hit & ~strobe;

   // Synchroniser chain for the asynchronous keypad pins, plus previous sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         kprev_q <= '0;
      end else begin
         if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], keypad};
         end else begin
            sync_q <= keypad;
         end
         kprev_q <= ksync;
      end
   end

   // Next-state decode: press handling first, then the idle timeout.
   always_comb begin
      state_d   = state_q;
      keycode_d = keycode_q;
      count_d   = count_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      tout_d    = 1'b0;
      accept    = 1'b0;
      if (strobe) begin
         if (!onehot) begin
            err_d = 1'b1;
         end else if (ksync[3]) begin
            keycode_d = '0;
            count_d   = '0;
            state_d   = S_IDLE;
            accept    = 1'b1;
         end else if (ksync[2]) begin
            if (state_q == S_IDLE) begin
               err_d = 1'b1;
            end else begin
               keycode_d = {1'b0, keycode_q[CODE_W-1:1]};
               count_d   = count_q - CNT_W'(1);
               state_d   = (count_q == CNT_W'(1)) ? S_IDLE : S_ENTRY;
               accept    = 1'b1;
            end
         end else begin
            if (state_q == S_FULL) begin
               err_d = 1'b1;
            end else begin
               keycode_d = {keycode_q[CODE_W-2:0], ksync[1]};
               count_d   = count_q + CNT_W'(1);
               accept    = 1'b1;
               if (count_q == CNT_W'(CODE_W-1)) begin
                  state_d = S_FULL;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ENTRY;
               end
            end
         end
      end else if (tmo_fire) begin
         keycode_d = '0;
         count_d   = '0;
         state_d   = S_IDLE;
         tout_d    = 1'b1;
      end
   end

   // State, code and the registered flag/pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         keycode_q <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         keycode_q <= keycode_d;
         count_q   <= count_d;
         full_q    <= (state_d == S_FULL);
         done_q    <= done_d;
         err_q     <= err_d;
         tout_q    <= tout_d;
      end
   end

   generate
      if (TIMEOUT_CYC > 0) begin : g_tmo
         logic [23:0] idle_q;

         assign tmo_hit = (state_q == S_ENTRY) && (idle_q >= 24'(TIMEOUT_CYC - 1));

         // Idle counter: runs only in ENTRY, restarts on every accepted press,
         // holds through a rejected press so an expiry is only postponed.
         always_ff @(posedge clk) begin
            if (rst || (state_q != S_ENTRY) || accept || tmo_fire) begin
               idle_q <= '0;
            end else if (!strobe) begin
               idle_q <= idle_q + 24'd1;
            end
         end
      end else begin : g_no_tmo
         logic tmo_unused;
         assign tmo_hit    = 1'b0;
         assign tmo_unused = accept ^ tmo_fire;
      end
   endgenerate

   assign keycode   = keycode_q;
   assign count     = count_q;
   assign code_full = full_q;
   assign code_done = done_q;
   assign key_err   = err_q;
   assign timeout   = tout_q;

endmodule

// File: tb/tb_key_encoder_nbit.sv
// Bench for key_encoder_nbit: two instances (9-digit/2-stage/100-cycle
// timeout and 4-digit/3-stage/no timeout) share one keypad and are compared
// every cycle against a digit-level model of the keypad rules.
module tb_key_encoder_nbit;
   localparam int W0 = 9, S0 = 2, T0 = 100;
   localparam int W1 = 4, S1 = 3, T1 = 0;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    keypad;

   logic [W0-1:0] kc0;
   logic [3:0]    cnt0;
   logic          full0, done0, err0, to0;
   logic [W1-1:0] kc1;
   logic [2:0]    cnt1;
   logic          full1, done1, err1, to1;

   always #5 clk = ~clk;

   key_encoder_nbit #(.CODE_W(W0), .SYNC_STAGES(S0), .TIMEOUT_CYC(T0)) dut0 (
      .clk(clk), .rst(rst), .keypad(keypad),
      .keycode(kc0), .count(cnt0), .code_full(full0),
      .code_done(done0), .key_err(err0), .timeout(to0)
   );

   key_encoder_nbit #(.CODE_W(W1), .SYNC_STAGES(S1), .TIMEOUT_CYC(T1)) dut1 (
      .clk(clk), .rst(rst), .keypad(keypad),
      .keycode(kc1), .count(cnt1), .code_full(full1),
      .code_done(done1), .key_err(err1), .timeout(to1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_done0 = 0, n_to0 = 0, n_err1 = 0;

   // Reference model state: the code as a number plus digit count.
   int unsigned m_code [2];
   int unsigned m_cnt  [2];
   int unsigned m_idle [2];
   bit          m_done [2];
   bit          m_err  [2];
   bit          m_tout [2];
   logic [3:0]  hist   [2][8];   // keypad value k+1 edges ago at index k

   function automatic int pw(input int i); return (i == 0) ? W0 : W1; endfunction
   function automatic int ps(input int i); return (i == 0) ? S0 : S1; endfunction
   function automatic int pt(input int i); return (i == 0) ? T0 : T1; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int i, input logic [3:0] kp, input bit r);
      logic [3:0] cur, prv;
      int w, s, t;
      w = pw(i); s = ps(i); t = pt(i);
      m_done[i] = 0; m_err[i] = 0; m_tout[i] = 0;
      if (r) begin
         m_code[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
         for (int k = 0; k < 8; k++) hist[i][k] = 4'd0;
      end else begin
         cur = hist[i][s-1];
         prv = hist[i][s];
         for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
         hist[i][0] = kp;
         if (cur != 4'd0 && prv == 4'd0) begin
            if ($countones(cur) != 1) begin
               m_err[i] = 1;
            end else if (cur[3]) begin
               m_code[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
            end else if (cur[2]) begin
               if (m_cnt[i] == 0) m_err[i] = 1;
               else begin
                  m_code[i] = m_code[i] >> 1;
                  m_cnt[i]  = m_cnt[i] - 1;
                  m_idle[i] = 0;
               end
            end else begin
               if (m_cnt[i] == w) m_err[i] = 1;
               else begin
                  m_code[i] = ((m_code[i] << 1) | 32'(cur[1])) & ((32'd1 << w) - 1);
                  m_cnt[i]  = m_cnt[i] + 1;
                  m_idle[i] = 0;
                  if (m_cnt[i] == w) m_done[i] = 1;
               end
            end
         end else if (t > 0 && m_cnt[i] > 0 && m_cnt[i] < w) begin
            m_idle[i] = m_idle[i] + 1;
            if (m_idle[i] == t) begin
               m_code[i] = 0; m_cnt[i] = 0; m_idle[i] = 0; m_tout[i] = 1;
            end
         end
      end
   endtask

   // One clock: drive inputs, advance the models, compare every output.
   task automatic step(input logic [3:0] kp, input bit r);
      keypad = kp;
      rst    = r;
      @(posedge clk);
      model_edge(0, kp, r);
      model_edge(1, kp, r);
      #1;
      chk("kc0",   32'(kc0),   m_code[0]);
      chk("cnt0",  32'(cnt0),  m_cnt[0]);
      chk("full0", 32'(full0), 32'(m_cnt[0] == W0));
      chk("done0", 32'(done0), 32'(m_done[0]));
      chk("err0",  32'(err0),  32'(m_err[0]));
      chk("to0",   32'(to0),   32'(m_tout[0]));
      chk("kc1",   32'(kc1),   m_code[1]);
      chk("cnt1",  32'(cnt1),  m_cnt[1]);
      chk("full1", 32'(full1), 32'(m_cnt[1] == W1));
      chk("done1", 32'(done1), 32'(m_done[1]));
      chk("err1",  32'(err1),  32'(m_err[1]));
      chk("to1",   32'(to1),   32'(m_tout[1]));
      if (done0) n_done0++;
      if (to0)   n_to0++;
      if (err1)  n_err1++;
   endtask

   task automatic press(input logic [3:0] kp, input int hold, input int gap);
      for (int h = 0; h < hold; h++) step(kp, 1'b0);
      for (int g = 0; g < gap; g++) step(4'd0, 1'b0);
      $display("press kp=%b hold=%0d gap=%0d -> code0=%h cnt0=%0d code1=%h cnt1=%0d",
               kp, hold, gap, kc0, cnt0, kc1, cnt1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(4'd0, 1'b0);
   endtask

   initial begin
      int n;
      int unsigned r;
      logic [3:0] kp;
      logic [8:0] seq;

      // Reset state
      for (int k = 0; k < 3; k++) step(4'd0, 1'b1);
      chk("rst_cnt0", 32'(cnt0), 0);

      // Full 9-digit code, newest digit in LSB
      seq = 9'b101100101;
      n_done0 = 0;
      for (int k = 8; k >= 0; k--) press(seq[k] ? 4'b0010 : 4'b0001, 1, 3);
      chk("full_code", 32'(kc0), 32'h165);
      chk("full_cnt", 32'(cnt0), 9);
      chk("full_flag", 32'(full0), 1);
      chk("done_once", 32'(n_done0), 1);
      press(4'b0010, 1, 3);                 // digit while FULL -> error
      chk("full_hold", 32'(kc0), 32'h165);
      press(4'b0100, 1, 3);                 // backspace
      chk("bksp_code", 32'(kc0), 32'h0B2);
      chk("bksp_cnt", 32'(cnt0), 8);
      chk("bksp_full", 32'(full0), 0);

      // Multi-key press and key added while another is held
      press(4'b1000, 1, 3);
      press(4'b0010, 1, 3);
      press(4'b0010, 1, 3);
      press(4'b0011, 1, 3);
      chk("multi_cnt", 32'(cnt0), 2);
      chk("multi_code", 32'(kc0), 3);
      for (int k = 0; k < 3; k++) step(4'b0001, 1'b0);
      for (int k = 0; k < 3; k++) step(4'b0011, 1'b0);
      idle(4);
      chk("held_cnt", 32'(cnt0), 3);
      chk("held_code", 32'(kc0), 6);

      // Timeout after exactly 100 idle cycles in ENTRY
      press(4'b1000, 1, 3);
      step(4'b0010, 1'b0);
      n = 0;
      while (cnt0 != 4'd1 && n < 10) begin step(4'd0, 1'b0); n++; end
      chk("acc_wait", 32'(cnt0), 1);
      n = 0;
      while (to0 != 1'b1 && n < 150) begin step(4'd0, 1'b0); n++; end
      chk("to_lat", 32'(n), 100);
      chk("to_cnt", 32'(cnt0), 0);

      // Press landing on the expiry cycle wins over the timeout
      step(4'b0010, 1'b0);
      n = 0;
      while (cnt0 != 4'd1 && n < 10) begin step(4'd0, 1'b0); n++; end
      n_to0 = 0;
      idle(97);
      step(4'b0001, 1'b0);
      idle(5);
      chk("exp_cnt", 32'(cnt0), 2);
      chk("exp_code", 32'(kc0), 2);
      chk("exp_noto", 32'(n_to0), 0);
      press(4'b1000, 1, 3);

      // Reset mid-entry with a press in flight
      for (int k = 0; k < 4; k++) press(4'b0010, 1, 3);
      step(4'b0001, 1'b0);
      step(4'd0, 1'b1);
      chk("mrst_code", 32'(kc0), 0);
      chk("mrst_cnt", 32'(cnt0), 0);
      idle(4);
      chk("mrst_pend", 32'(cnt0), 0);
      press(4'b1000, 1, 3);                 // clear in IDLE: no error

      // Three-stage synchroniser latency, backspace in IDLE
      step(4'b0010, 1'b0);
      n = 0;
      while (kc1[0] != 1'b1 && n < 8) begin step(4'b0010, 1'b0); n++; end
      chk("sync3_lat", 32'(n), 3);
      idle(2);
      press(4'b1000, 1, 4);
      n_err1 = 0;
      press(4'b0100, 1, 4);
      chk("bksp_idle", 32'(n_err1), 1);

      // Randomised presses, idles and resets
      for (int p = 0; p < 300; p++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      kp = 4'b0001;
         else if (r < 80) kp = 4'b0010;
         else if (r < 88) kp = 4'b0100;
         else if (r < 91) kp = 4'b1000;
         else             kp = 4'($urandom_range(1, 15));
         press(kp, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 29) == 0) idle(int'($urandom_range(95, 105)));
         if ($urandom_range(0, 79) == 0) step(4'd0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
